// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive path: K28.5 comma patterns, aligner
// state encoding, counter widths and a ones-count helper.
package phy_rx_pkg;

  // K28.5 in both running-disparity forms, bit a at [9]
  localparam logic [9:0] COMMA_RDN = 10'b0011111010;
  localparam logic [9:0] COMMA_RDP = 10'b1100000101;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    SEARCH = ST_SEARCH,
    ALIGN  = ST_ALIGN,
    LOCKED = ST_LOCKED
  } state_t;

  localparam int BCNT_W = 4;  // bit position 0..9
  localparam int CCNT_W = 3;  // up to LOCK_COMMAS = 7
  localparam int ECNT_W = 4;  // up to ERR_LIMIT = 15

  function automatic logic [3:0] ones_count(input logic [9:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_disparity_checker.sv
// Combinational 10b symbol check: ones count gives code validity, and the
// count against the current running disparity gives the disparity flag and
// the next running disparity (0 = negative).
module rx_disparity_checker
  import phy_rx_pkg::*;
(
  input  logic [9:0] sym,
  input  logic       rd,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd_next
);

  logic [3:0] ones;

  assign ones = ones_count(sym);

  // Balanced symbols keep rd; 6 ones must start negative, 4 ones positive
  always_comb begin
    code_err = 1'b0;
    disp_err = 1'b0;
    rd_next  = rd;
    case (ones)
      4'd4: begin
        disp_err = ~rd;
        rd_next  = 1'b0;
      end
      4'd5: ;
      4'd6: begin
        disp_err = rd;
        rd_next  = 1'b1;
      end
      default: code_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rx_symbol_aligner.sv
// Receive symbol aligner: finds K28.5 commas in the serial stream, frames
// 10-bit symbols, runs the SEARCH/ALIGN/LOCKED lock machine and flags code
// and disparity errors per symbol.
// Build option: define RX_DISPARITY_CHECK_EN to track running disparity and
// raise disp_err; otherwise disp_err is 0 and only code errors count.
module rx_symbol_aligner
  import phy_rx_pkg::*;
#(
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned ERR_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [9:0] sym_10b,
  output logic       sym_valid,
  output logic       locked,
  output logic       code_err,
  output logic       disp_err
);

  // Only the nine newest bits are stored; serial_in supplies the tenth
  logic [8:0]        sh;
  logic [9:0]        nxt;
  logic [BCNT_W-1:0] bcnt;
  logic [CCNT_W-1:0] ccnt;
  logic [ECNT_W-1:0] ecnt;
  state_t            state;

  logic comma_match;
  logic boundary;
  logic align_set;
  logic sym_check;
  logic chk_code;
  logic chk_disp;
  logic bad;

  assign nxt         = {sh, serial_in};
  assign comma_match = (nxt == COMMA_RDN) || (nxt == COMMA_RDP);
  assign boundary    = (bcnt == BCNT_W'(9));

  // A comma seen while searching, or off-boundary while aligning, sets framing
  assign align_set = comma_match &&
                     ((state == SEARCH) || ((state == ALIGN) && !boundary));
  assign sym_check = boundary && ((state == ALIGN) || (state == LOCKED));

`ifdef RX_DISPARITY_CHECK_EN
  logic rd;
  logic rd_next;

  rx_disparity_checker u_disp_chk (
    .sym      (nxt),
    .rd       (rd),
    .code_err (chk_code),
    .disp_err (chk_disp),
    .rd_next  (rd_next)
  );

  // rd follows every checked symbol; an aligning comma reloads it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= 1'b0;
    end else if (align_set) begin
      rd <= (nxt == COMMA_RDN);
    end else if (sym_check) begin
      rd <= rd_next;
    end
  end
`else
  logic [3:0] ones;

  assign ones     = ones_count(nxt);
  assign chk_code = (ones < 4'd4) || (ones > 4'd6);
  assign chk_disp = 1'b0;
`endif

  assign bad = chk_code | chk_disp;

  // Lock state machine with registered symbol and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh        <= '0;
      bcnt      <= '0;
      ccnt      <= '0;
      ecnt      <= '0;
      state     <= SEARCH;
      sym_10b   <= 10'h000;
      sym_valid <= 1'b0;
      locked    <= 1'b0;
      code_err  <= 1'b0;
      disp_err  <= 1'b0;
    end else begin
      sh        <= nxt[8:0];
      sym_valid <= 1'b0;
      bcnt      <= boundary ? '0 : bcnt + BCNT_W'(1);
      if (align_set) begin
        bcnt      <= '0;
        ccnt      <= CCNT_W'(1);
        ecnt      <= '0;
        sym_10b   <= nxt;
        sym_valid <= 1'b1;
        code_err  <= 1'b0;
        disp_err  <= 1'b0;
        if (LOCK_COMMAS == 1) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end else begin
          state  <= ALIGN;
          locked <= 1'b0;
        end
      end else if (sym_check) begin
        sym_10b   <= nxt;
        sym_valid <= 1'b1;
        code_err  <= chk_code;
        disp_err  <= chk_disp;
        case (state)
          ALIGN: begin
            if (comma_match) begin
              if (32'(ccnt) + 32'd1 >= LOCK_COMMAS) begin
                state  <= LOCKED;
                locked <= 1'b1;
                ecnt   <= '0;
              end else begin
                ccnt <= ccnt + CCNT_W'(1);
              end
            end
          end
          LOCKED: begin
            if (bad) begin
              if (32'(ecnt) + 32'd1 >= ERR_LIMIT) begin
                state  <= SEARCH;
                locked <= 1'b0;
                ecnt   <= '0;
                ccnt   <= '0;
              end else begin
                ecnt <= ecnt + ECNT_W'(1);
              end
            end else begin
              ecnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Self-checking bench for rx_symbol_aligner: a table of framed symbols for
// lock, disparity and error-limit behaviour, plus hand sequences for
// re-alignment and asynchronous reset.
module tb_rx_symbol_aligner;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
`ifdef RX_DISPARITY_CHECK_EN
  localparam logic DISP_ON = 1'b1;
`else
  localparam logic DISP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [9:0] sym_10b;
  logic       sym_valid;
  logic       locked;
  logic       code_err;
  logic       disp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] sym;
    logic       exp_locked;
    logic       chk_locked;
    logic       exp_code;
    logic       exp_disp;
  } vec_t;

  vec_t vecs[9];

  rx_symbol_aligner #(
    .LOCK_COMMAS (3),
    .ERR_LIMIT   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .sym_10b   (sym_10b),
    .sym_valid (sym_valid),
    .locked    (locked),
    .code_err  (code_err),
    .disp_err  (disp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, leave time #1 past the sampling edge
  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send the top n bits of w, bit [9] first; count strobes before the last bit
  task automatic send_n(input logic [9:0] w, input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      send_bit(w[9-i]);
      if (i != n - 1 && sym_valid) strobes++;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    int         mid;
    int         hold_bad;
    logic [9:0] prev;
    mid      = 0;
    hold_bad = 0;
    prev     = sym_10b;
    for (int i = 9; i >= 0; i--) begin
      send_bit(v.sym[i]);
      if (i != 0) begin
        if (sym_valid) mid++;
        if (sym_10b !== prev) hold_bad++;
      end
    end
    check($sformatf("v%0d_mid_strobe", k), 32'(mid), 32'd0);
    check($sformatf("v%0d_hold", k), 32'(hold_bad), 32'd0);
    check($sformatf("v%0d_valid", k), 32'(sym_valid), 32'd1);
    check($sformatf("v%0d_sym", k), 32'(sym_10b), 32'(v.sym));
    check($sformatf("v%0d_code", k), 32'(code_err), 32'(v.exp_code));
    check($sformatf("v%0d_disp", k), 32'(disp_err), 32'(v.exp_disp));
    if (v.chk_locked) check($sformatf("v%0d_locked", k), 32'(locked), 32'(v.exp_locked));
  endtask

  initial begin
    int s;

    // Comma lock, then disparity hit, recovery, and error-limit loss of lock
    vecs[0] = '{K_RDN,         1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{K_RDP,         1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{K_RDN,         1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{10'b1110011100, 1'b1, 1'b1, 1'b0, DISP_ON};
    vecs[4] = '{10'b1010101010, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{10'b1111111111, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{10'b1111111111, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{10'b1111111111, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{10'b1111111111, 1'b0, 1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym", 32'(sym_10b), 32'd0);
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_code", 32'(code_err), 32'd0);
    check("rst_disp", 32'(disp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle line places the first comma at bit offset 7
    send_n(10'd0, 7, s);
    check("idle_strobes", 32'(s + int'(sym_valid)), 32'd0);

    for (int k = 0; k < 9; k++) apply_vec(vecs[k], k);

    // Lock drops right after the fourth bad symbol and framing stops
    send_bit(1'b1);
    check("drop_locked", 32'(locked), 32'd0);
    check("drop_valid", 32'(sym_valid), 32'd0);
    send_n(10'h3ff, 10, s);
    s = s + int'(sym_valid);
    begin
      int s2;
      send_n(10'h3ff, 10, s2);
      s = s + s2 + int'(sym_valid);
    end
    check("search_no_strobe", 32'(s), 32'd0);

    // Re-align: comma arrives 3 bits late while aligning
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_n(K_RDN, 10, s);
    check("ra_c1_valid", 32'(sym_valid), 32'd1);
    check("ra_c1_locked", 32'(locked), 32'd0);
    send_n(10'b0001100000, 10, s);
    check("ra_mis_mid", 32'(s), 32'd0);
    check("ra_mis_valid", 32'(sym_valid), 32'd1);
    check("ra_mis_sym", 32'(sym_10b), 32'(10'b0001100000));
    check("ra_mis_code", 32'(code_err), 32'd1);
    send_n(10'b1010000000, 3, s);
    check("ra_shift_mid", 32'(s), 32'd0);
    check("ra_shift_valid", 32'(sym_valid), 32'd1);
    check("ra_shift_sym", 32'(sym_10b), 32'(K_RDP));
    check("ra_shift_code", 32'(code_err), 32'd0);
    check("ra_shift_locked", 32'(locked), 32'd0);
    send_n(K_RDN, 10, s);
    check("ra_c2_mid", 32'(s), 32'd0);
    check("ra_c2_valid", 32'(sym_valid), 32'd1);
    check("ra_c2_locked", 32'(locked), 32'd0);
    check("ra_c2_disp", 32'(disp_err), 32'd0);
    send_n(K_RDP, 10, s);
    check("ra_c3_valid", 32'(sym_valid), 32'd1);
    check("ra_c3_locked", 32'(locked), 32'd1);
    check("ra_c3_disp", 32'(disp_err), 32'd0);

    // Asynchronous reset in the middle of a symbol while locked
    send_n(10'b1010101010, 4, s);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("ar_sym", 32'(sym_10b), 32'd0);
    check("ar_valid", 32'(sym_valid), 32'd0);
    check("ar_locked", 32'(locked), 32'd0);
    check("ar_code", 32'(code_err), 32'd0);
    check("ar_disp", 32'(disp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_n(10'd0, 7, s);
    send_n(K_RDN, 10, s);
    check("rl_c1_valid", 32'(sym_valid), 32'd1);
    check("rl_c1_locked", 32'(locked), 32'd0);
    send_n(K_RDP, 10, s);
    check("rl_c2_locked", 32'(locked), 32'd0);
    send_n(K_RDN, 10, s);
    check("rl_c3_valid", 32'(sym_valid), 32'd1);
    check("rl_c3_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_symbol_aligner.md
# rx_symbol_aligner

Receive-side symbol aligner for the PCIe-style PHY: deserializes the incoming line bit stream, finds K28.5 commas, establishes 10-bit symbol boundaries, and delivers aligned 10-bit symbols to the 8b/10b decoder.
It runs a lock state machine and per-symbol code/disparity checking, so downstream logic sees only framed symbols plus lock and error status.
It is the receiving counterpart of the transmit path formed by the 8b/10b encoder and serializer.

## Interface
- LOCK_COMMAS, 3: consecutive boundary-aligned commas required to declare lock (range 1..7).
- ERR_LIMIT, 4: consecutive bad symbols in LOCKED that drop lock (range 1..15).
- clk  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  line bit; first bit of a symbol is bit a.
- sym_10b  output  10  aligned symbol, abcdei fghj with a at [9]; reset 10'h000.
- sym_valid  output  1  one-cycle strobe, sym_10b is valid; reset 0.
- locked  output  1  high in LOCKED state; reset 0.
- code_err  output  1  qualified by sym_valid, ones count not in {4,5,6}; reset 0.
- disp_err  output  1  qualified by sym_valid, running-disparity violation; reset 0.

## Operation
- Shift register sh[9:0] <= {sh[8:0], serial_in} every cycle; nxt = {sh[8:0], serial_in}.
- Comma match: nxt == 10'b0011111010 (K28.5 RD-) or 10'b1100000101 (K28.5 RD+).
- Bit counter bcnt 0..9; boundary when bcnt == 9, then wraps to 0.
- States:
  - SEARCH: no symbols emitted. On comma match → bcnt := 0, ccnt := 1, emit the comma as a symbol, go to ALIGN. If LOCK_COMMAS == 1, go directly to LOCKED.
  - ALIGN: emit a symbol at each boundary.
    - Comma at boundary → ccnt++; on reaching LOCK_COMMAS → LOCKED.
    - Non-comma at boundary → ccnt unchanged.
    - Comma match off-boundary → re-align: bcnt := 0, ccnt := 1, emit the comma.
  - LOCKED: emit a symbol at each boundary; off-boundary commas are ignored.
    - Bad symbol (code_err or disp_err) → ecnt++; on reaching ERR_LIMIT → SEARCH, with locked low the following cycle.
    - Good symbol → ecnt := 0.
- Running disparity rd (0 = negative):
  - Loaded from every comma that sets alignment: RD- comma → rd := 1, RD+ comma → rd := 0.
  - Per symbol: ones == 6 needs rd == 0, then rd := 1. Ones == 4 needs rd == 1, then rd := 0. Ones == 5 leaves rd unchanged.
  - A violation flags disp_err, and rd is still updated per the symbol.
  - Ones count outside {4,5,6} flags code_err only, and rd is unchanged.
- Errors are reported in ALIGN and LOCKED; only LOCKED counts them toward ERR_LIMIT.
- Reset mid-operation: all state cleared immediately, SEARCH, rd = 0, ccnt = ecnt = bcnt = 0.

## Timing
- sym_10b, sym_valid, code_err and disp_err are registered. They appear the cycle after the edge that samples the symbol's last bit, which is a latency of 1 clk.
- Once aligned, sym_valid is high exactly 1 cycle in every 10.
- locked rises in the same cycle sym_valid presents the LOCK_COMMAS-th comma.
- A re-align restarts the 10-cycle cadence: the next sym_valid comes 10 cycles after the re-align strobe.
- Outside sym_valid cycles, sym_10b, code_err and disp_err hold their last values.

## Configuration
- RX_DISPARITY_CHECK_EN defined: rd is tracked and disp_err is generated as above.
- RX_DISPARITY_CHECK_EN undefined: no rd register, disp_err tied to 0, and only code_err counts as a bad symbol.

## Structure
- Shared package phy_rx_pkg holds:
  - COMMA_RDN and COMMA_RDP constants.
  - State encoding SEARCH/ALIGN/LOCKED as localparams.
  - Counter widths.
- One sub-module, rx_disparity_checker: combinational ones count with code/disparity flags and next-rd, instantiated inside the RX_DISPARITY_CHECK_EN region for the rd path.

## Test plan
- Idle line, then 3× K28.5 RD-/RD+ alternating at bit offset 7 → sym_valid every 10 clk, locked high on the 3rd comma, code_err = disp_err = 0.
- Locked, then 4 consecutive 10'b1111111111 → code_err on each, locked low 1 cycle after the 4th, no sym_valid afterwards until a new comma.
- Locked with rd = 1, then a symbol with 6 ones (10'b1110011100) → disp_err = 1, ecnt = 1; a following good D-symbol clears ecnt and lock is held.
- In ALIGN after 1 comma, a comma inserted 3 bits late → cadence shifts by 3, ccnt restarts at 1, lock needs 2 more boundary commas.
- Locked, with reset asserted asynchronously mid-symbol → all outputs 0 immediately, re-lock requires 3 fresh commas.
- RX_DISPARITY_CHECK_EN undefined, rerun scenario 3 → disp_err stays 0, no error counted.
